// File: rtl/ram_arbiter_2port.sv
// rtl/ram_arbiter_2port.sv - two-port arbiter/sequencer for a shared single-port 32-bit RAM
module ram_arbiter_2port #(
    parameter int ACCESS_CYCLES  = 1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [15:0] p0_req_addr,
    input  logic        p0_req_is_write,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [15:0] p1_req_addr,
    input  logic        p1_req_is_write,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,

    output logic [15:0] ram_address,
    output logic        ram_is_write,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    logic [3:0] counter;
    logic       last_grant;
    logic       owner;
    logic       grant;
    logic       accept;

    // Round-robin favours the port that did not win last; reset value 1 lets port 0 win the first tie.
    always_comb begin
        grant = p1_req_valid;
        if (p0_req_valid && p1_req_valid) begin
            grant = FIXED_PRIORITY ? 1'b1 : ~last_grant;
        end
    end

    assign p0_req_ready = (state == IDLE) && !grant && p0_req_valid;
    assign p1_req_ready = (state == IDLE) &&  grant && p1_req_valid;
    assign accept       = p0_req_ready || p1_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            counter       <= 4'd0;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            ram_address   <= 16'd0;
            ram_in        <= 32'd0;
            ram_is_write  <= 1'b0;
            p0_resp_valid <= 1'b0;
            p0_resp_rdata <= 32'd0;
            p1_resp_valid <= 1'b0;
            p1_resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ram_address  <= grant ? p1_req_addr     : p0_req_addr;
                        ram_in       <= grant ? p1_req_wdata    : p0_req_wdata;
                        ram_is_write <= grant ? p1_req_is_write : p0_req_is_write;
                        owner        <= grant;
                        last_grant   <= grant;
                        counter      <= CNT_LOAD;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (counter == 4'd0) begin
                        // Writes capture the RAM's write-through output, i.e. the written data.
                        ram_is_write <= 1'b0;
                        state        <= RESP;
                        if (owner) begin
                            p1_resp_valid <= 1'b1;
                            p1_resp_rdata <= ram_out;
                        end else begin
                            p0_resp_valid <= 1'b1;
                            p0_resp_rdata <= ram_out;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    p0_resp_valid <= 1'b0;
                    p1_resp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    ram_is_write <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// tb/tb_ram_arbiter_2port.sv - directed self-checking bench for ram_arbiter_2port
module tb_ram_arbiter_2port;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: round-robin, 1 cycle; 1: fixed priority, 1 cycle; 2: round-robin, 3 cycles.
    logic [2:0]        p0_req_valid = '0, p0_req_ready, p0_req_is_write = '0, p0_resp_valid;
    logic [2:0][15:0]  p0_req_addr = '0;
    logic [2:0][31:0]  p0_req_wdata = '0, p0_resp_rdata;
    logic [2:0]        p1_req_valid = '0, p1_req_ready, p1_req_is_write = '0, p1_resp_valid;
    logic [2:0][15:0]  p1_req_addr = '0;
    logic [2:0][31:0]  p1_req_wdata = '0, p1_resp_rdata;
    logic [2:0][15:0]  ram_address;
    logic [2:0]        ram_is_write;
    logic [2:0][31:0]  ram_in, ram_out;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [0:65535];

        ram_arbiter_2port #(
            .ACCESS_CYCLES  ((g == 2) ? 3 : 1),
            .FIXED_PRIORITY (g == 1)
        ) dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .p0_req_valid    (p0_req_valid[g]),
            .p0_req_ready    (p0_req_ready[g]),
            .p0_req_addr     (p0_req_addr[g]),
            .p0_req_is_write (p0_req_is_write[g]),
            .p0_req_wdata    (p0_req_wdata[g]),
            .p0_resp_valid   (p0_resp_valid[g]),
            .p0_resp_rdata   (p0_resp_rdata[g]),
            .p1_req_valid    (p1_req_valid[g]),
            .p1_req_ready    (p1_req_ready[g]),
            .p1_req_addr     (p1_req_addr[g]),
            .p1_req_is_write (p1_req_is_write[g]),
            .p1_req_wdata    (p1_req_wdata[g]),
            .p1_resp_valid   (p1_resp_valid[g]),
            .p1_resp_rdata   (p1_resp_rdata[g]),
            .ram_address     (ram_address[g]),
            .ram_is_write    (ram_is_write[g]),
            .ram_in          (ram_in[g]),
            .ram_out         (ram_out[g])
        );

        always @(posedge clk) if (ram_is_write[g]) mem[ram_address[g]] <= ram_in[g];
        assign ram_out[g] = ram_is_write[g] ? ram_in[g] : mem[ram_address[g]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on one port; returns rdata, latency (accept cycle = 0), is_write cycles and a sequencing flag.
    task automatic access(input int i, input bit port, input logic [15:0] addr, input bit we,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output int wcnt, output bit ok);
        bit acc;
        ok = 1'b1; lat = 0; wcnt = 0; rd = '0; acc = 1'b0;
        @(negedge clk);
        if (port) begin
            p1_req_valid[i] = 1'b1; p1_req_addr[i] = addr; p1_req_is_write[i] = we; p1_req_wdata[i] = wd;
        end else begin
            p0_req_valid[i] = 1'b1; p0_req_addr[i] = addr; p0_req_is_write[i] = we; p0_req_wdata[i] = wd;
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = port ? p1_req_ready[i] : p0_req_ready[i];
            if (acc) break;
            @(negedge clk);
        end
        check_eq($sformatf("accept i%0d p%0d", i, port), {31'd0, acc}, 32'd1);
        if (!acc) begin
            p0_req_valid[i] = 1'b0; p1_req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Deassert and scramble the request so any late sampling shows up.
        if (port) begin
            p1_req_valid[i] = 1'b0; p1_req_addr[i] = ~addr; p1_req_wdata[i] = ~wd; p1_req_is_write[i] = ~we;
        end else begin
            p0_req_valid[i] = 1'b0; p0_req_addr[i] = ~addr; p0_req_wdata[i] = ~wd; p0_req_is_write[i] = ~we;
        end
        for (int n = 0; n < 40; n++) begin
            if (ram_is_write[i]) wcnt++;
            if (ram_address[i] !== addr) ok = 1'b0;
            if (p0_req_ready[i] || p1_req_ready[i]) ok = 1'b0;
            if (port ? p0_resp_valid[i] : p1_resp_valid[i]) ok = 1'b0;
            if (port ? p1_resp_valid[i] : p0_resp_valid[i]) begin
                lat = n + 1;
                rd  = port ? p1_resp_rdata[i] : p0_resp_rdata[i];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (p0_resp_valid[i] || p1_resp_valid[i]) ok = 1'b0;
    endtask

    // Both ports held valid; records the first n grants (bit k = winning port), p1 drops after p1_stop grants.
    task automatic contend(input int i, input int n, input int p1_stop, output logic [3:0] order, output bit ok);
        int  g, p1g;
        bit  own;
        g = 0; p1g = 0; own = 1'b0; ok = 1'b1; order = '0;
        @(negedge clk);
        p0_req_valid[i] = 1'b1; p0_req_addr[i] = 16'h0001; p0_req_is_write[i] = 1'b1; p0_req_wdata[i] = 32'h1;
        p1_req_valid[i] = 1'b1; p1_req_addr[i] = 16'h0002; p1_req_is_write[i] = 1'b1; p1_req_wdata[i] = 32'h2;
        for (int c = 0; c < 60 && g < n; c++) begin
            #1;
            if (p0_req_ready[i] && p1_req_ready[i]) ok = 1'b0;
            if (p0_req_ready[i] || p1_req_ready[i]) begin
                own = p1_req_ready[i];
                order[g] = own;
                g++;
                if (own) p1g++;
            end
            @(posedge clk); #1;
            if (own ? p0_resp_valid[i] : p1_resp_valid[i]) ok = 1'b0;
            if (p1g >= p1_stop) p1_req_valid[i] = 1'b0;
            @(negedge clk);
        end
        p0_req_valid[i] = 1'b0; p1_req_valid[i] = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, wc;
        bit          ok, any;
        logic [3:0]  ord;

        #12;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst ram_is_write i%0d", i), {31'd0, ram_is_write[i]}, 32'd0);
            check_eq($sformatf("rst ram_address i%0d", i), {16'd0, ram_address[i]}, 32'd0);
            check_eq($sformatf("rst ram_in i%0d", i), ram_in[i], 32'd0);
            check_eq($sformatf("rst resp_valid i%0d", i), {30'd0, p1_resp_valid[i], p0_resp_valid[i]}, 32'd0);
            check_eq($sformatf("rst p0 rdata i%0d", i), p0_resp_rdata[i], 32'd0);
            check_eq($sformatf("rst p1 rdata i%0d", i), p1_resp_rdata[i], 32'd0);
        end
        @(negedge clk); reset_n = 1'b1;

        contend(0, 4, 99, ord, ok);
        check_eq("rr grant order", {28'd0, ord}, 32'h0000_000A);
        check_eq("rr no cross resp", {31'd0, ok}, 32'd1);
        contend(1, 4, 3, ord, ok);
        check_eq("fixed grant order", {28'd0, ord}, 32'h0000_0007);
        check_eq("fixed no cross resp", {31'd0, ok}, 32'd1);

        access(0, 1, 16'h0002, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("rr rd addr2", rd, 32'h2);
        access(0, 0, 16'h0001, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("rr rd addr1", rd, 32'h1);

        access(0, 0, 16'hC3BC, 1'b1, 32'hE5F84AB1, rd, lat, wc, ok);
        check_eq("p0 wr lat", lat, 32'd2);
        check_eq("p0 wr we cycles", wc, 32'd1);
        check_eq("p0 wr rdata", rd, 32'hE5F84AB1);
        check_eq("p0 wr seq", {31'd0, ok}, 32'd1);
        access(0, 0, 16'hC3BC, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("p0 rd rdata", rd, 32'hE5F84AB1);
        check_eq("p0 rd we cycles", wc, 32'd0);
        access(0, 1, 16'hB83A, 1'b1, 32'h5C8C6A01, rd, lat, wc, ok);
        check_eq("p1 wr lat", lat, 32'd2);
        check_eq("p1 wr seq", {31'd0, ok}, 32'd1);
        access(0, 0, 16'hC3BC, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("iso p0 rd", rd, 32'hE5F84AB1);
        access(0, 1, 16'hB83A, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("iso p1 rd", rd, 32'h5C8C6A01);
        check_eq("p0 rdata hold", p0_resp_rdata[0], 32'hE5F84AB1);

        access(0, 1, 16'hFFFF, 1'b1, 32'hA5A50001, rd, lat, wc, ok);
        access(0, 1, 16'h0000, 1'b1, 32'h5A5A0002, rd, lat, wc, ok);
        access(0, 1, 16'hFFFF, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("rd addr ffff", rd, 32'hA5A50001);
        access(0, 1, 16'h0000, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("rd addr 0000", rd, 32'h5A5A0002);

        access(2, 0, 16'h1234, 1'b1, 32'hDEADBEEF, rd, lat, wc, ok);
        check_eq("ac3 wr lat", lat, 32'd4);
        check_eq("ac3 wr we cycles", wc, 32'd3);
        check_eq("ac3 wr seq", {31'd0, ok}, 32'd1);
        access(2, 0, 16'h1234, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("ac3 rd lat", lat, 32'd4);
        check_eq("ac3 rd rdata", rd, 32'hDEADBEEF);
        check_eq("ac3 rd seq", {31'd0, ok}, 32'd1);

        @(negedge clk);
        p0_req_valid[2] = 1'b1; p0_req_addr[2] = 16'h0055; p0_req_is_write[2] = 1'b1; p0_req_wdata[2] = 32'h11111111;
        @(posedge clk); #1;
        p0_req_valid[2] = 1'b0;
        check_eq("abort pre we", {31'd0, ram_is_write[2]}, 32'd1);
        @(negedge clk); reset_n = 1'b0; #1;
        check_eq("abort we drop", {31'd0, ram_is_write[2]}, 32'd0);
        check_eq("abort addr rst", {16'd0, ram_address[2]}, 32'd0);
        check_eq("abort p0 rdata rst", p0_resp_rdata[2], 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        any = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            any = any | p0_resp_valid[2] | p1_resp_valid[2] | ram_is_write[2];
        end
        check_eq("abort no resp", {31'd0, any}, 32'd0);
        access(2, 0, 16'h0055, 1'b1, 32'h22222222, rd, lat, wc, ok);
        check_eq("post abort wr lat", lat, 32'd4);
        access(2, 0, 16'h0055, 1'b0, 32'h0, rd, lat, wc, ok);
        check_eq("post abort rd", rd, 32'h22222222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2port.md
Name: ram_arbiter_2port

Overview:
- Two-requester arbiter and sequencer for the shared single-port RAM_32bit_16aline (16-bit address, 32-bit data, level-sensitive is_write).
- Port 0 is the instruction-fetch port; port 1 is the load/store port.
- The block accepts one request at a time via a valid/ready handshake, drives the RAM for a fixed number of access cycles, then returns a one-cycle response to the winning requester.
- Ties are resolved by round-robin or fixed priority, selected by parameter.

Parameters:
- ACCESS_CYCLES, 1: cycles the RAM address/data/is_write are held stable per access; legal range 1..15.
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 1 always wins ties.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  port 0 request present.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_addr  in  16  port 0 word address.
- p0_req_is_write  in  1  1 = write, 0 = read.
- p0_req_wdata  in  32  port 0 write data.
- p0_resp_valid  out  1  one-cycle pulse: port 0 access complete.
- p0_resp_rdata  out  32  data returned to port 0.
- p1_*  (same seven signals for port 1, same directions and widths).
- ram_address  out  16  to RAM address.
- ram_is_write  out  1  to RAM is_write.
- ram_in  out  32  to RAM in.
- ram_out  in  32  from RAM out.

Behaviour:
- States:
  - IDLE → ACCESS on any accepted request.
  - ACCESS (counter counts ACCESS_CYCLES) → RESP when the counter expires.
  - RESP → IDLE unconditionally.
- Reset (async, reset_n=0) forces:
  - state=IDLE, counter=0, last_grant=1 (port 0 wins the first tie);
  - all resp_valid=0, resp_rdata=0;
  - ram_is_write=0, ram_address=0, ram_in=0.
  - ram_is_write must fall within the same delta as reset assertion.
- Grant (combinational, IDLE only):
  - Only one valid → that port.
  - Both valid, FIXED_PRIORITY=0 → the port not equal to last_grant.
  - Both valid, FIXED_PRIORITY=1 → port 1.
  - px_req_ready = (state==IDLE) && grant==x && px_req_valid. Ready is 0 in ACCESS and RESP.
- Handshake: a request transfers on a posedge with valid&&ready. On transfer the block:
  - latches addr, is_write, wdata and the owner into internal registers;
  - updates last_grant;
  - enters ACCESS.
  - Requester inputs are ignored after transfer.
- ACCESS:
  - ram_address and ram_in are driven from the latched registers for all ACCESS_CYCLES cycles.
  - ram_is_write = latched is_write, asserted only in ACCESS and registered (glitch-free). It is 0 in IDLE and RESP.
- On the last ACCESS cycle's posedge, ram_out is captured into the owner's resp_rdata.
  - For writes the captured value is the RAM's write-through out, which equals the written data.
- RESP: owner's resp_valid=1 for exactly one cycle. The non-owner's resp_valid stays 0.
- Holds:
  - resp_rdata holds until that port's next response.
  - ram_address and ram_in hold their last values in IDLE and RESP.
- Latency: accept edge T → resp_valid high during cycle T+ACCESS_CYCLES+1. Throughput is one access per ACCESS_CYCLES+2 cycles.
- A requester holding valid through RESP is re-arbitrated in the following IDLE cycle. There is no back-to-back acceptance from RESP.
- Counter arithmetic: 4-bit; loads ACCESS_CYCLES-1 on accept, decrements in ACCESS; exit when it reaches 0. No wrap.
- Reset mid-ACCESS:
  - the access is aborted, no response is issued, ram_is_write drops immediately;
  - RAM contents are not guaranteed for an aborted write.
- Address 16'hFFFF and 16'h0000 are ordinary addresses; no wrap logic is applied.

Test Plan:
- Single write/read, port 0, ACCESS_CYCLES=1:
  - write addr 16'hC3BC, data 32'hE5F84AB1 → p0_resp_valid pulse at accept+2, ram_is_write high exactly 1 cycle.
  - read same addr → p0_resp_rdata=32'hE5F84AB1.
- Both ports valid continuously, round-robin:
  - p0 write 16'h0001/32'h1, p1 write 16'h0002/32'h2 → grants alternate p0,p1,p0,p1.
  - p1_resp_valid never pulses for a p0 access.
- FIXED_PRIORITY=1, both valid for 3 requests → p1 granted all three; p0 granted only after p1_req_valid drops.
- Isolation:
  - p1 writes 16'hB83A=32'h5C8C6A01, then p0 reads 16'hC3BC → 32'hE5F84AB1.
  - p1 reads 16'hB83A → 32'h5C8C6A01.
- ACCESS_CYCLES=3:
  - ram_address stable for 3 cycles; resp at accept+4; ready low throughout ACCESS/RESP.
  - Changing p0_req_addr after accept has no effect.
- reset_n pulled low during ACCESS of a write → ram_is_write=0 immediately, no resp_valid, state IDLE; the next request completes normally.
